// File: rtl/uart_wb_if_pkg.sv
// Shared UART Wishbone bridge definitions: FSM encodings, timeout default and
// byte-lane count helpers.
package uart_wb_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } wb_state_e;

  localparam int UART_WB_TIMEOUT = 15;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // Address bits consumed by the lane number; zero for a byte-wide bus.
  function automatic int lane_bits(input int data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 0;
  endfunction

endpackage

// File: rtl/uart_wb_if_if.sv
// Wishbone bus bundle between a host master and the UART register bridge.
interface uart_wb_bus #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                    wb_cyc;
  logic                    wb_stb;
  logic                    wb_we;
  logic [DATA_WIDTH/8-1:0] wb_sel;
  logic [ADDR_WIDTH-1:0]   wb_adr;
  logic [DATA_WIDTH-1:0]   wb_dat_w;
  logic [DATA_WIDTH-1:0]   wb_dat_r;
  logic                    wb_ack;
  logic                    wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface

// File: rtl/uart_wb_lane.sv
// Byte-lane decode for the bridge: sel legality, core address, write byte
// extraction and read-data lane placement.
module uart_wb_lane
  import uart_wb_if_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                    we_r,
  input  logic [DATA_WIDTH/8-1:0] sel_r,
  input  logic [ADDR_WIDTH-1:0]   adr_r,
  input  logic [DATA_WIDTH-1:0]   dat_r,
  input  logic [7:0]              dat8_i,
  input  logic [DATA_WIDTH-1:0]   datw_i,
  output logic                    legal_s,
  output logic [ADDR_WIDTH-1:0]   adr_s,
  output logic [7:0]              dat8_s,
  output logic [DATA_WIDTH-1:0]   rdata_s
);

  localparam int NL = lane_count(DATA_WIDTH);
  localparam int LB = lane_bits(DATA_WIDTH);
  localparam int IW = (LB > 0) ? LB : 1;

  logic          onehot_s;
  logic          allones_s;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] lane_s;

  // Decode the hot lane, legality and steered data from the registered request.
  always_comb begin
    idx_s = IW'(0);
    for (int i = 0; i < NL; i++) begin
      idx_s = sel_r[i] ? IW'(i) : idx_s;
    end
    onehot_s  = (sel_r != NL'(0)) && ((sel_r & (sel_r - NL'(1))) == NL'(0));
    allones_s = &sel_r;
    legal_s   = (NL == 1) ? 1'b1 : (onehot_s | (allones_s & ~we_r));
    if (onehot_s) begin
      lane_s = (BIG_ENDIAN != 0) ? (IW'(NL - 1) - idx_s) : idx_s;
      dat8_s = dat_r[int'(idx_s)*8 +: 8];
    end else begin
      lane_s = IW'(0);
      dat8_s = 8'h00;
    end
    rdata_s = {DATA_WIDTH{1'b0}};
    if (allones_s && (NL > 1)) begin
      rdata_s = datw_i;
    end else if (onehot_s || (NL == 1)) begin
      rdata_s[int'(idx_s)*8 +: 8] = dat8_i;
    end else begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  generate
    if (LB == 0) begin : g_byte_bus
      logic unused_lane_s;
      assign unused_lane_s = ^lane_s;
      assign adr_s = adr_r;
    end else begin : g_wide_bus
      logic unused_adr_s;
      assign unused_adr_s = ^adr_r[LB-1:0];
      assign adr_s = {adr_r[ADDR_WIDTH-1:LB], lane_s[LB-1:0]};
    end
  endgenerate

endmodule

// File: rtl/uart_wb_if.sv
// Wishbone slave bridge to the UART core register file: registers the bus,
// issues single-cycle core strobes and terminates with ack, err or timeout.
module uart_wb_if
  import uart_wb_if_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = UART_WB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  uart_wb_bus.slave             wb,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [7:0]            dat8_o,
  input  logic [7:0]            dat8_i,
  input  logic [DATA_WIDTH-1:0] datw_i,
  output logic                  we_o,
  output logic                  re_o,
  input  logic                  rdy_i
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic                    cyc_r;
  logic                    stb_r;
  logic                    we_r;
  logic [DATA_WIDTH/8-1:0] sel_r;
  logic [ADDR_WIDTH-1:0]   adr_r;
  logic [DATA_WIDTH-1:0]   dat_r;
  wb_state_e               state_r;
  logic [7:0]              cnt_r;
  logic                    legal_s;
  logic [ADDR_WIDTH-1:0]   adr_s;
  logic [7:0]              dat8_s;
  logic [DATA_WIDTH-1:0]   rdata_s;

  uart_wb_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .we_r    (we_r),
    .sel_r   (sel_r),
    .adr_r   (adr_r),
    .dat_r   (dat_r),
    .dat8_i  (dat8_i),
    .datw_i  (datw_i),
    .legal_s (legal_s),
    .adr_s   (adr_s),
    .dat8_s  (dat8_s),
    .rdata_s (rdata_s)
  );

  // Single input stage; the FSM only ever looks at these copies.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_r <= 1'b0;
      stb_r <= 1'b0;
      we_r  <= 1'b0;
      sel_r <= {(DATA_WIDTH/8){1'b0}};
      adr_r <= {ADDR_WIDTH{1'b0}};
      dat_r <= {DATA_WIDTH{1'b0}};
    end else begin
      cyc_r <= wb.wb_cyc;
      stb_r <= wb.wb_stb;
      we_r  <= wb.wb_we;
      sel_r <= wb.wb_sel;
      adr_r <= wb.wb_adr;
      dat_r <= wb.wb_dat_w;
    end
  end

  // Transfer FSM with registered strobes, terminations and read data.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      we_o        <= 1'b0;
      re_o        <= 1'b0;
      adr_o       <= {ADDR_WIDTH{1'b0}};
      dat8_o      <= 8'h00;
      wb.wb_ack   <= 1'b0;
      wb.wb_err   <= 1'b0;
      wb.wb_dat_r <= {DATA_WIDTH{1'b0}};
    end else begin
      we_o      <= 1'b0;
      re_o      <= 1'b0;
      wb.wb_ack <= 1'b0;
      wb.wb_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cyc_r && stb_r && legal_s) begin
            state_r <= ST_STROBE;
            we_o    <= we_r;
            re_o    <= ~we_r;
            adr_o   <= adr_s;
            dat8_o  <= dat8_s;
          end else if (cyc_r && stb_r) begin
            state_r     <= ST_RESP;
            wb.wb_err   <= 1'b1;
            wb.wb_dat_r <= {DATA_WIDTH{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_STROBE: begin
          if (!cyc_r) begin
            state_r <= ST_IDLE;
          end else if (rdy_i) begin
            state_r   <= ST_RESP;
            wb.wb_ack <= 1'b1;
            if (!we_r) wb.wb_dat_r <= rdata_s;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (!cyc_r) begin
            state_r <= ST_IDLE;
          end else if (rdy_i) begin
            state_r   <= ST_RESP;
            wb.wb_ack <= 1'b1;
            if (!we_r) wb.wb_dat_r <= rdata_s;
          end else if (cnt_r >= TIMEOUT_C) begin
            state_r     <= ST_RESP;
            wb.wb_err   <= 1'b1;
            wb.wb_dat_r <= {DATA_WIDTH{1'b0}};
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP:    state_r <= ST_RECOVER;
        ST_RECOVER: begin
          state_r <= ST_IDLE;
          cnt_r   <= 8'd0;
        end
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_if.sv
// Directed bench: three bridge instances (32-bit LE with TIMEOUT=3, 32-bit BE,
// 8-bit) share one stimulus stream; each test checks the instance it targets.
module tb_uart_wb_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_v, stb_v, we_v, rdy_v;
  logic [3:0]  sel_v;
  logic [4:0]  adr_v;
  logic [31:0] dat_v, datw_v;
  logic [7:0]  dat8_v;
  int          cur;
  int          total = 0;
  int          bad   = 0;

  logic [4:0] le_adr, be_adr, b8_adr;
  logic [7:0] le_d8, be_d8, b8_d8;
  logic       le_we, le_re, be_we, be_re, b8_we, b8_re;

  logic        obs_re, obs_we, obs_ack, obs_err;
  logic [4:0]  obs_adr;
  logic [7:0]  obs_d8;
  logic [31:0] obs_dato;

  always #5 clk = ~clk;

  uart_wb_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_le ();
  uart_wb_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_be ();
  uart_wb_bus #(.DATA_WIDTH(8),  .ADDR_WIDTH(5)) bus_b8 ();

  assign bus_le.wb_cyc = cyc_v;  assign bus_be.wb_cyc = cyc_v;  assign bus_b8.wb_cyc = cyc_v;
  assign bus_le.wb_stb = stb_v;  assign bus_be.wb_stb = stb_v;  assign bus_b8.wb_stb = stb_v;
  assign bus_le.wb_we  = we_v;   assign bus_be.wb_we  = we_v;   assign bus_b8.wb_we  = we_v;
  assign bus_le.wb_sel = sel_v;  assign bus_be.wb_sel = sel_v;  assign bus_b8.wb_sel = sel_v[0];
  assign bus_le.wb_adr = adr_v;  assign bus_be.wb_adr = adr_v;  assign bus_b8.wb_adr = adr_v;
  assign bus_le.wb_dat_w = dat_v; assign bus_be.wb_dat_w = dat_v; assign bus_b8.wb_dat_w = dat_v[7:0];

  uart_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BIG_ENDIAN(0), .TIMEOUT(3)) u_le (
    .clk(clk), .wb_rst_i(rst), .wb(bus_le), .adr_o(le_adr), .dat8_o(le_d8),
    .dat8_i(dat8_v), .datw_i(datw_v), .we_o(le_we), .re_o(le_re), .rdy_i(rdy_v));
  uart_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BIG_ENDIAN(1), .TIMEOUT(15)) u_be (
    .clk(clk), .wb_rst_i(rst), .wb(bus_be), .adr_o(be_adr), .dat8_o(be_d8),
    .dat8_i(dat8_v), .datw_i(datw_v), .we_o(be_we), .re_o(be_re), .rdy_i(rdy_v));
  uart_wb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .BIG_ENDIAN(0), .TIMEOUT(15)) u_b8 (
    .clk(clk), .wb_rst_i(rst), .wb(bus_b8), .adr_o(b8_adr), .dat8_o(b8_d8),
    .dat8_i(dat8_v), .datw_i(datw_v[7:0]), .we_o(b8_we), .re_o(b8_re), .rdy_i(rdy_v));

  always_comb begin
    case (cur)
      0: begin
        obs_re = le_re; obs_we = le_we; obs_ack = bus_le.wb_ack; obs_err = bus_le.wb_err;
        obs_adr = le_adr; obs_d8 = le_d8; obs_dato = bus_le.wb_dat_r;
      end
      1: begin
        obs_re = be_re; obs_we = be_we; obs_ack = bus_be.wb_ack; obs_err = bus_be.wb_err;
        obs_adr = be_adr; obs_d8 = be_d8; obs_dato = bus_be.wb_dat_r;
      end
      default: begin
        obs_re = b8_re; obs_we = b8_we; obs_ack = bus_b8.wb_ack; obs_err = bus_b8.wb_err;
        obs_adr = b8_adr; obs_d8 = b8_d8; obs_dato = {24'h0, bus_b8.wb_dat_r};
      end
    endcase
  end

  // Runs one host access on all instances and records what the selected one did.
  // Cycle c counts falling edges after the request is applied; c=1 follows the
  // edge that registers stb, so STROBE is seen at c=2 and an immediate ack at c=3.
  task automatic xfer(input logic we, input logic [3:0] sel, input logic [4:0] adr,
                      input logic [31:0] dat, input int release_after, input int drop_at,
                      output int n_re, output int n_we, output int n_ack, output int n_err,
                      output int first_ack, output int last_ack, output int err_at,
                      output logic [4:0] adr_seen, output logic [7:0] d8_seen);
    n_re = 0; n_we = 0; n_ack = 0; n_err = 0;
    first_ack = -1; last_ack = -1; err_at = -1; adr_seen = 5'h1F; d8_seen = 8'hEE;
    @(negedge clk);
    cyc_v = 1'b1; stb_v = 1'b1; we_v = we; sel_v = sel; adr_v = adr; dat_v = dat;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (obs_re) begin n_re++; adr_seen = obs_adr; d8_seen = obs_d8; end
      if (obs_we) begin n_we++; adr_seen = obs_adr; d8_seen = obs_d8; end
      if (obs_ack) begin n_ack++; last_ack = c; if (first_ack < 0) first_ack = c; end
      if (obs_err) begin n_err++; if (err_at < 0) err_at = c; end
      if ((n_ack + n_err >= release_after) || (c == drop_at)) begin
        cyc_v = 1'b0; stb_v = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cur = d; #1;
      total++;
      if ({obs_re, obs_we, obs_ack, obs_err, obs_adr, obs_d8, obs_dato} !== 49'd0) begin
        bad++; $display("FAIL reset_outputs dut%0d: got %h want 0", d,
                        {obs_re, obs_we, obs_ack, obs_err, obs_adr, obs_d8, obs_dato});
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_read_le();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 0; rdy_v = 1'b1; dat8_v = 8'hA5;
    xfer(1'b0, 4'b0100, 5'h04, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (a !== 5'h06) begin bad++; $display("FAIL le_read_adr: got %h want 06", a); end
    total++; if (nr !== 1 || nw !== 0) begin bad++; $display("FAIL le_read_strobes: re=%0d we=%0d want 1/0", nr, nw); end
    total++; if (fa !== 3 || na !== 1 || ne !== 0) begin bad++; $display("FAIL le_read_ack: at=%0d n=%0d err=%0d want 3/1/0", fa, na, ne); end
    total++; if (obs_dato !== 32'h00A50000) begin bad++; $display("FAIL le_read_data: got %h want 00a50000", obs_dato); end
  endtask

  task automatic test_write_be();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 1; rdy_v = 1'b1;
    xfer(1'b1, 4'b0001, 5'h08, 32'h000000C3, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (a !== 5'h0B || d !== 8'hC3) begin bad++; $display("FAIL be_write_adr_dat: got %h/%h want 0b/c3", a, d); end
    total++; if (nw !== 1 || nr !== 0 || na !== 1 || ne !== 0) begin
      bad++; $display("FAIL be_write_handshake: we=%0d re=%0d ack=%0d err=%0d want 1/0/1/0", nw, nr, na, ne); end
    total++; if (obs_dato !== 32'h00A50000) begin bad++; $display("FAIL be_write_keeps_data: got %h want 00a50000", obs_dato); end
  endtask

  task automatic test_timeout();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 0; rdy_v = 1'b0;
    xfer(1'b0, 4'b0001, 5'h00, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (ea !== 6 || ne !== 1 || na !== 0) begin bad++; $display("FAIL timeout_err: at=%0d n=%0d ack=%0d want 6/1/0", ea, ne, na); end
    total++; if (nr !== 1) begin bad++; $display("FAIL timeout_single_re: got %0d want 1", nr); end
    total++; if (obs_dato !== 32'h0) begin bad++; $display("FAIL timeout_data: got %h want 0", obs_dato); end
  endtask

  task automatic test_full_word();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 0; rdy_v = 1'b1; datw_v = 32'h12345678;
    xfer(1'b0, 4'b1111, 5'h06, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (obs_dato !== 32'h12345678 || na !== 1) begin bad++; $display("FAIL word_read: got %h ack=%0d want 12345678/1", obs_dato, na); end
    total++; if (a !== 5'h04 || d !== 8'h00) begin bad++; $display("FAIL word_read_adr: got %h/%h want 04/00", a, d); end
    xfer(1'b1, 4'b1111, 5'h06, 32'hDEADBEEF, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (ea !== 2 || ne !== 1 || na !== 0 || nw !== 0) begin
      bad++; $display("FAIL word_write_err: at=%0d err=%0d ack=%0d we=%0d want 2/1/0/0", ea, ne, na, nw); end
    total++; if (obs_dato !== 32'h0) begin bad++; $display("FAIL word_write_data: got %h want 0", obs_dato); end
  endtask

  task automatic test_illegal_sel();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 0; rdy_v = 1'b1;
    xfer(1'b0, 4'b0011, 5'h00, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (ne !== 1 || nr !== 0 || na !== 0) begin bad++; $display("FAIL sel_multi: err=%0d re=%0d ack=%0d want 1/0/0", ne, nr, na); end
    xfer(1'b0, 4'b0000, 5'h00, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (ne !== 1 || nr !== 0 || na !== 0) begin bad++; $display("FAIL sel_zero: err=%0d re=%0d ack=%0d want 1/0/0", ne, nr, na); end
  endtask

  task automatic test_abort();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 0; rdy_v = 1'b0;
    xfer(1'b0, 4'b0001, 5'h00, 32'h0, 1, 3, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (na !== 0 || ne !== 0 || nr !== 1) begin bad++; $display("FAIL abort: ack=%0d err=%0d re=%0d want 0/0/1", na, ne, nr); end
    rdy_v = 1'b1; dat8_v = 8'h77;
    xfer(1'b0, 4'b0001, 5'h00, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (fa !== 3 || obs_dato !== 32'h00000077) begin bad++; $display("FAIL after_abort: ack_at=%0d data=%h want 3/00000077", fa, obs_dato); end
  endtask

  task automatic test_reset_mid();
    cur = 0; rdy_v = 1'b0;
    @(negedge clk);
    cyc_v = 1'b1; stb_v = 1'b1; we_v = 1'b0; sel_v = 4'b0001; adr_v = 5'h10;
    repeat (3) @(negedge clk);
    total++; if (obs_adr !== 5'h10 || obs_dato !== 32'h77) begin bad++; $display("FAIL wait_state_pre: adr=%h data=%h want 10/77", obs_adr, obs_dato); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({obs_re, obs_we, obs_ack, obs_err, obs_adr, obs_d8, obs_dato} !== 49'd0) begin
      bad++; $display("FAIL reset_in_wait: got %h want 0", {obs_re, obs_we, obs_ack, obs_err, obs_adr, obs_d8, obs_dato});
    end
    cyc_v = 1'b0; stb_v = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nr, nw, na, ne, fa, la, ea; logic [4:0] a; logic [7:0] d;
    cur = 2; rdy_v = 1'b1;
    xfer(1'b1, 4'b0001, 5'h13, 32'h0000005A, 2, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (na !== 2 || fa !== 3 || la !== 7) begin bad++; $display("FAIL b2b_acks: n=%0d first=%0d last=%0d want 2/3/7", na, fa, la); end
    total++; if (nw !== 2 || nr !== 0) begin bad++; $display("FAIL b2b_strobes: we=%0d re=%0d want 2/0", nw, nr); end
    total++; if (a !== 5'h13 || d !== 8'h5A) begin bad++; $display("FAIL b2b_adr_dat: got %h/%h want 13/5a", a, d); end
    dat8_v = 8'h3C;
    xfer(1'b0, 4'b0001, 5'h02, 32'h0, 1, 0, nr, nw, na, ne, fa, la, ea, a, d);
    total++; if (obs_dato !== 32'h3C || na !== 1) begin bad++; $display("FAIL b8_read: got %h ack=%0d want 3c/1", obs_dato, na); end
  endtask

  initial begin
    rst = 1'b1; cyc_v = 1'b0; stb_v = 1'b0; we_v = 1'b0; sel_v = 4'h0; adr_v = 5'h0;
    dat_v = 32'h0; datw_v = 32'h0; dat8_v = 8'h0; rdy_v = 1'b0; cur = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read_le();
    test_write_be();
    test_timeout();
    test_full_word();
    test_illegal_sel();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
